// File: rtl/coinc_pkg.sv
// Shared types and elaboration helpers for the coincidence acquisition sequencer.
// Also provides the channel-pair to counter-index mapping used by benches.
package coinc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACQ    = 3'd2,
    SETTLE = 3'd3,
    READ   = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic int ncomb(input int nchan);
    return nchan * (nchan - 1) / 2;
  endfunction

  // Never narrower than one bit, even for a single pair counter.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pairs are enumerated (0,1),(0,2)..(0,N-1),(1,2).. in ascending order.
  function automatic int pair_idx(input int i, input int j, input int nchan);
    int lo;
    int hi;
    int idx;
    lo  = (i < j) ? i : j;
    hi  = (i < j) ? j : i;
    idx = 0;
    for (int k = 0; k < lo; k++) begin
      idx += nchan - 1 - k;
    end
    return idx + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/coinc_snapshot_mux.sv
// Snapshot register bank for the pair counters with an index-selected read port.
// Loaded once per run; read combinationally from the registered copy only.
module coinc_snapshot_mux
  import coinc_pkg::*;
#(
  parameter int NCOMB = 6,
  parameter int NBITS = 4,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [NBITS-1:0] counts_in [NCOMB],
  input  logic [IDXW-1:0]  rd_idx,
  output logic [NBITS-1:0] rd_data
);

  logic [NBITS-1:0] snap_q [NCOMB];
  logic [NBITS-1:0] snap_d [NCOMB];

  for (genvar gi = 0; gi < NCOMB; gi++) begin : g_snap
    assign snap_d[gi] = load_en ? counts_in[gi] : snap_q[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_q[gi] <= '0;
      end else begin
        snap_q[gi] <= snap_d[gi];
      end
    end
  end

  // Explicit compare keeps unused index codes at zero instead of out-of-range reads.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCOMB; k++) begin
      if (rd_idx == IDXW'(k)) begin
        rd_data = snap_q[k];
      end
    end
  end

endmodule

// File: rtl/coinc_acq_ctrl.sv
// Run sequencer: clear detector, gate a timed window, drain the pipeline,
// snapshot the pair counters and stream them out over valid/ready.
module coinc_acq_ctrl
  import coinc_pkg::*;
#(
  parameter  int NCHAN   = 4,
  parameter  int NBITS   = 4,
  parameter  int NREGS   = 4,
  parameter  int WINBITS = 16,
  localparam int NCOMB   = ncomb(NCHAN),
  localparam int IDXW    = idx_width(NCOMB)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic [WINBITS-1:0] WindowLen,
  input  logic [NBITS-1:0]   Counts [NCOMB],
  output logic               DetClear,
  output logic               DetEnable,
  output logic [NBITS-1:0]   OutData,
  output logic [IDXW-1:0]    OutIdx,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Busy,
  output logic               Done
);

  localparam int SETW = $clog2(NREGS + 2);

  state_t             state_q, state_d;
  logic [WINBITS-1:0] win_len_q, win_len_d;
  logic [WINBITS-1:0] win_cnt_q, win_cnt_d;
  logic [SETW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               snap_load;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      win_len_q    <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      win_cnt_q    <= win_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_len_d    = win_len_q;
    win_cnt_d    = win_cnt_q;
    settle_cnt_d = settle_cnt_q;
    idx_d        = idx_q;
    snap_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          win_len_d = (WindowLen == '0) ? WINBITS'(1) : WindowLen;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        win_cnt_d = win_len_q;
        state_d   = ACQ;
      end
      ACQ: begin
        win_cnt_d = win_cnt_q - WINBITS'(1);
        if (win_cnt_q == WINBITS'(1)) begin
          settle_cnt_d = SETW'(NREGS + 1);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q - SETW'(1);
        if (settle_cnt_q == SETW'(1)) begin
          snap_load = 1'b1;
          idx_d     = '0;
          state_d   = READ;
        end
      end
      READ: begin
        if (OutReady) begin
          if (idx_q == IDXW'(NCOMB - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a pending snapshot load.
    if (Abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      snap_load = 1'b0;
    end
  end

  coinc_snapshot_mux #(
    .NCOMB (NCOMB),
    .NBITS (NBITS),
    .IDXW  (IDXW)
  ) u_snap (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load_en   (snap_load),
    .counts_in (Counts),
    .rd_idx    (idx_q),
    .rd_data   (OutData)
  );

  assign DetClear  = (state_q == CLEAR);
  assign DetEnable = (state_q == ACQ);
  assign OutValid  = (state_q == READ);
  assign Done      = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign OutIdx    = idx_q;

endmodule

// File: tb/tb_coinc_acq_ctrl.sv
// Scoreboard bench for coinc_acq_ctrl: stimulus queues expected words and window
// lengths, a negedge monitor pops and compares on each transfer and Done pulse.
module tb_coinc_acq_ctrl;
  import coinc_pkg::*;

  localparam int NCHAN   = 4;
  localparam int NBITS   = 4;
  localparam int NREGS   = 4;
  localparam int WINBITS = 16;
  localparam int NCOMB   = ncomb(NCHAN);
  localparam int IDXW    = idx_width(NCOMB);

  logic               Clk;
  logic               Rst_n;
  logic               Start;
  logic               Abort;
  logic [WINBITS-1:0] WindowLen;
  logic [NBITS-1:0]   Counts [NCOMB];
  logic               DetClear;
  logic               DetEnable;
  logic [NBITS-1:0]   OutData;
  logic [IDXW-1:0]    OutIdx;
  logic               OutValid;
  logic               OutReady;
  logic               Busy;
  logic               Done;

  coinc_acq_ctrl #(
    .NCHAN   (NCHAN),
    .NBITS   (NBITS),
    .NREGS   (NREGS),
    .WINBITS (WINBITS)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Abort     (Abort),
    .WindowLen (WindowLen),
    .Counts    (Counts),
    .DetClear  (DetClear),
    .DetEnable (DetEnable),
    .OutData   (OutData),
    .OutIdx    (OutIdx),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [IDXW-1:0]  idx;
    logic [NBITS-1:0] data;
  } word_t;

  word_t exp_word_q[$];
  int    exp_win_q[$];
  int    exp_vals[NCOMB];
  int    checks = 0;
  int    passes = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor state
  int               en_run = 0;
  int               settle_run = 0;
  int               clr_run = 0;
  bit               hold_pend = 0;
  logic [IDXW-1:0]  held_idx;
  logic [NBITS-1:0] held_data;
  word_t            w;
  int               win_exp;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      hold_pend = 0;
      clr_run   = 0;
    end else begin
      if (!Busy) clr_run = 0;
      if (DetClear) begin
        clr_run++;
        en_run     = 0;
        settle_run = 0;
      end else if (DetEnable) begin
        en_run++;
      end else if (Busy && !OutValid && !Done) begin
        settle_run++;
      end

      if (OutValid) begin
        if (hold_pend) begin
          check("hold_idx", OutIdx, held_idx);
          check("hold_data", OutData, held_data);
        end
        if (OutReady) begin
          hold_pend = 0;
          if (exp_word_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got idx=%0d data=%0d, expected no transfer", OutIdx, OutData);
          end else begin
            w = exp_word_q.pop_front();
            $display("xfer idx=%0d data=%0d (exp idx=%0d data=%0d)", OutIdx, OutData, w.idx, w.data);
            check("word_idx", OutIdx, w.idx);
            check("word_data", OutData, w.data);
          end
        end else begin
          hold_pend = 1;
          held_idx  = OutIdx;
          held_data = OutData;
        end
      end else begin
        hold_pend = 0;
      end

      if (Done) begin
        done_cnt++;
        if (exp_win_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got Done pulse %0d, expected none", done_cnt);
        end else begin
          win_exp = exp_win_q.pop_front();
          $display("done run=%0d acq=%0d settle=%0d clear=%0d", done_cnt, en_run, settle_run, clr_run);
          check("acq_cycles", en_run, win_exp);
          check("settle_cycles", settle_run, NREGS + 1);
          check("clear_cycles", clr_run, 1);
        end
        check("words_left_at_done", exp_word_q.size(), 0);
        check("done_outvalid", OutValid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int k = 0; k < n; k++) begin
      exp_word_q.push_back('{idx: IDXW'(k), data: NBITS'(exp_vals[k])});
    end
  endtask

  task automatic start_run(input int win);
    WindowLen = WINBITS'(win);
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  // Waits for the target Done count; bp applies a 1,0,0,1 OutReady pattern.
  task automatic wait_done(input int target, input bit bp, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      if (bp) OutReady = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
      k++;
    end
    if (done_cnt < target) begin
      checks++;
      $display("FAIL done_timeout: got %0d Done pulses, expected %0d", done_cnt, target);
    end else begin
      check("busy_after_done", Busy, 0);
      check("done_one_cycle", Done, 0);
    end
    OutReady = 1'b1;
  endtask

  task automatic wait_enable(input int budget);
    int k;
    k = 0;
    while (!DetEnable && k < budget) begin
      tick();
      k++;
    end
    if (!DetEnable) begin
      checks++;
      $display("FAIL enable_timeout: got DetEnable=0, expected 1");
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!OutValid && k < budget) begin
      tick();
      k++;
    end
    if (!OutValid) begin
      checks++;
      $display("FAIL valid_timeout: got OutValid=0, expected 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    Rst_n     = 1'b1;
    Start     = 1'b0;
    Abort     = 1'b0;
    WindowLen = '0;
    OutReady  = 1'b1;
    for (int i = 0; i < NCOMB; i++) Counts[i] = '0;
    #1 Rst_n = 1'b0;
    #2;
    check("rst_busy", Busy, 0);
    check("rst_detclear", DetClear, 0);
    check("rst_detenable", DetEnable, 0);
    check("rst_outvalid", OutValid, 0);
    check("rst_done", Done, 0);
    check("rst_outidx", OutIdx, 0);
    check("rst_outdata", OutData, 0);
    tick();
    tick();
    Rst_n = 1'b1;
    tick();

    // Basic run, counts equal to their index; counts scrambled after snapshot.
    for (int i = 0; i < NCOMB; i++) begin
      Counts[i]   = NBITS'(i);
      exp_vals[i] = i;
    end
    push_words(NCOMB);
    exp_win_q.push_back(10);
    start_run(10);
    check("clear_first_cycle", DetClear, 1);
    check("busy_in_clear", Busy, 1);
    check("enable_off_in_clear", DetEnable, 0);
    wait_valid(100);
    for (int i = 0; i < NCOMB; i++) Counts[i] = 4'hF;
    wait_done(1, 0, 100);

    // Backpressure with pair-addressed counts.
    for (int i = 0; i < NCHAN; i++)
      for (int j = i + 1; j < NCHAN; j++)
        Counts[pair_idx(i, j, NCHAN)] = NBITS'(i * 4 + j);
    exp_vals = '{1, 2, 3, 6, 7, 11};
    push_words(NCOMB);
    exp_win_q.push_back(10);
    start_run(10);
    wait_done(2, 1, 300);

    // Zero window behaves as one cycle; counts at the top of range.
    for (int i = 0; i < NCOMB; i++) begin
      Counts[i]   = NBITS'(15 - i);
      exp_vals[i] = 15 - i;
    end
    push_words(NCOMB);
    exp_win_q.push_back(1);
    start_run(0);
    wait_done(3, 0, 100);

    // Start pulses during ACQ and READ are ignored.
    for (int i = 0; i < NCOMB; i++) begin
      Counts[i]   = NBITS'(i + 8);
      exp_vals[i] = i + 8;
    end
    push_words(NCOMB);
    exp_win_q.push_back(6);
    start_run(6);
    OutReady = 1'b0;
    wait_enable(20);
    WindowLen = 16'd3;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    wait_valid(100);
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
    OutReady  = 1'b1;
    wait_done(4, 0, 100);
    repeat (15) tick();
    check("single_run_done_count", done_cnt, 4);
    check("no_second_run_busy", Busy, 0);

    // Abort at OutIdx=2, then Abort suppressing Start in IDLE.
    for (int i = 0; i < NCOMB; i++) begin
      Counts[i]   = NBITS'(i * 2);
      exp_vals[i] = i * 2;
    end
    push_words(2);
    start_run(8);
    OutReady = 1'b1;
    k = 0;
    while (!(OutValid && OutIdx == IDXW'(2)) && k < 100) begin
      tick();
      k++;
    end
    check("abort_reached_idx2", OutIdx, 2);
    OutReady = 1'b0;
    Abort    = 1'b1;
    tick();
    Abort    = 1'b0;
    OutReady = 1'b1;
    check("abort_outvalid", OutValid, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    repeat (3) tick();
    check("abort_no_done", done_cnt, 4);
    Start = 1'b1;
    Abort = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    check("abort_idle_busy", Busy, 0);
    check("abort_idle_clear", DetClear, 0);
    tick();
    check("abort_idle_busy2", Busy, 0);

    // Asynchronous reset in the middle of a long window.
    start_run(20);
    wait_enable(20);
    repeat (4) tick();
    check("pre_reset_enable", DetEnable, 1);
    Rst_n = 1'b0;
    #2;
    check("midrst_detenable", DetEnable, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_detclear", DetClear, 0);
    check("midrst_outvalid", OutValid, 0);
    check("midrst_done", Done, 0);
    check("midrst_outidx", OutIdx, 0);
    check("midrst_outdata", OutData, 0);
    tick();
    tick();
    Rst_n = 1'b1;
    repeat (30) tick();
    check("midrst_no_done", done_cnt, 4);
    check("midrst_idle", Busy, 0);

    // Recovery run after reset.
    for (int i = 0; i < NCOMB; i++) begin
      Counts[i]   = NBITS'(5 - i);
      exp_vals[i] = 5 - i;
    end
    push_words(NCOMB);
    exp_win_q.push_back(2);
    start_run(2);
    wait_done(5, 0, 100);

    tick();
    check("final_word_queue_empty", exp_word_q.size(), 0);
    check("final_run_queue_empty", exp_win_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
